// File: rtl/ltl_symbol_feeder.sv
// Buffers trace samples and frames each trace for the LTL automata with a monitor reset.
// Latency is 2 edges while streaming and 2+RST_CYCLES from idle; evt_ready drops only when the FIFO is full.
module ltl_symbol_feeder_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_dat,
    output logic         o_full,
    output logic         o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == OCC_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dat   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + OCC_W'(1);
                2'b01:   r_count <= r_count - OCC_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

module ltl_symbol_feeder #(
    parameter int DEPTH      = 16,
    parameter int RST_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             evt_valid,
    input  logic [3:0]       evt_props,
    input  logic [3:0]       evt_aux,
    input  logic             evt_last,
    output logic             evt_ready,
    output logic [7:0]       symbols,
    output logic             run,
    output logic             mon_reset,
    output logic             busy,
    output logic [CNT_W-1:0] trace_cnt,
    output logic [CNT_W-1:0] sym_cnt
);
    localparam int SOR_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SOR,
        S_STREAM
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SOR_W-1:0] r_sor_cnt;
    logic [SOR_W-1:0] w_sor_cnt_nxt;
    logic [7:0]       r_symbols;
    logic [7:0]       w_symbols_nxt;
    logic             r_run;
    logic             w_run_nxt;
    logic             r_mon_reset;
    logic             w_mon_reset_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic [CNT_W-1:0] r_trace_cnt;
    logic [CNT_W-1:0] w_trace_cnt_nxt;
    logic [CNT_W-1:0] r_sym_cnt;
    logic [CNT_W-1:0] w_sym_cnt_nxt;

    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [8:0]       w_head;

    assign w_push = evt_valid && !w_full;

    ltl_symbol_feeder_fifo #(
        .DEPTH (DEPTH),
        .W     (9)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_dat   ({evt_last, evt_props, evt_aux}),
        .i_pop   (w_pop),
        .o_dat   (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_sor_cnt_nxt   = r_sor_cnt;
        w_pop           = 1'b0;
        w_symbols_nxt   = r_symbols;
        w_run_nxt       = 1'b0;
        w_mon_reset_nxt = 1'b1;
        w_last_nxt      = r_last;
        w_trace_cnt_nxt = r_trace_cnt;
        w_sym_cnt_nxt   = r_sym_cnt;
        case (r_state)
            S_IDLE: begin
                w_sor_cnt_nxt = '0;
                if (!w_empty) begin
                    w_state_nxt = S_SOR;
                end
            end
            S_SOR: begin
                // The first pop coincides with mon_reset falling, so start_of_data lands on it.
                if (r_sor_cnt == SOR_W'(RST_CYCLES - 1)) begin
                    w_pop           = 1'b1;
                    w_symbols_nxt   = w_head[7:0];
                    w_last_nxt      = w_head[8];
                    w_run_nxt       = 1'b1;
                    w_mon_reset_nxt = 1'b0;
                    w_sym_cnt_nxt   = CNT_W'(1);
                    w_state_nxt     = S_STREAM;
                end else begin
                    w_sor_cnt_nxt = r_sor_cnt + SOR_W'(1);
                end
            end
            S_STREAM: begin
                w_mon_reset_nxt = 1'b0;
                if (r_last) begin
                    w_mon_reset_nxt = 1'b1;
                    w_trace_cnt_nxt = r_trace_cnt + CNT_W'(1);
                    w_state_nxt     = S_IDLE;
                end else if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_symbols_nxt = w_head[7:0];
                    w_last_nxt    = w_head[8];
                    w_run_nxt     = 1'b1;
                    if (r_sym_cnt != '1) begin
                        w_sym_cnt_nxt = r_sym_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sor_cnt   <= '0;
            r_symbols   <= '0;
            r_run       <= 1'b0;
            r_mon_reset <= 1'b1;
            r_last      <= 1'b0;
            r_trace_cnt <= '0;
            r_sym_cnt   <= '0;
        end else begin
            r_sor_cnt   <= w_sor_cnt_nxt;
            r_symbols   <= w_symbols_nxt;
            r_run       <= w_run_nxt;
            r_mon_reset <= w_mon_reset_nxt;
            r_last      <= w_last_nxt;
            r_trace_cnt <= w_trace_cnt_nxt;
            r_sym_cnt   <= w_sym_cnt_nxt;
        end
    end

    assign evt_ready = !w_full;
    assign symbols   = r_symbols;
    assign run       = r_run;
    assign mon_reset = r_mon_reset;
    assign busy      = (r_state != S_IDLE) || !w_empty;
    assign trace_cnt = r_trace_cnt;
    assign sym_cnt   = r_sym_cnt;
endmodule

// File: tb/tb_ltl_symbol_feeder.sv
// Bench for ltl_symbol_feeder: reset state, vector table, directed corners, randomized model check.
module tb_ltl_symbol_feeder;
    localparam int DEPTH      = 16;
    localparam int RST_CYCLES = 2;
    localparam int CNT_W      = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             evt_valid;
    logic [3:0]       evt_props;
    logic [3:0]       evt_aux;
    logic             evt_last;
    logic             evt_ready;
    logic [7:0]       symbols;
    logic             run;
    logic             mon_reset;
    logic             busy;
    logic [CNT_W-1:0] trace_cnt;
    logic [CNT_W-1:0] sym_cnt;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state: accepted-but-unemitted samples and trace framing.
    logic [8:0]  m_q [$];
    logic        m_in_trace;
    logic        m_prev_last;
    int          m_wait;
    logic [7:0]  m_sym;
    logic [15:0] m_tc;
    logic [15:0] m_sc;
    logic        saw_full;

    typedef struct packed {
        logic        v;
        logic [3:0]  p;
        logic [3:0]  a;
        logic        l;
        logic [7:0]  sym;
        logic        run;
        logic        mrst;
        logic        busy;
        logic [15:0] tc;
        logic [15:0] sc;
    } vec_t;
    vec_t tbl [7];

    ltl_symbol_feeder #(
        .DEPTH      (DEPTH),
        .RST_CYCLES (RST_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .evt_valid (evt_valid),
        .evt_props (evt_props),
        .evt_aux   (evt_aux),
        .evt_last  (evt_last),
        .evt_ready (evt_ready),
        .symbols   (symbols),
        .run       (run),
        .mon_reset (mon_reset),
        .busy      (busy),
        .trace_cnt (trace_cnt),
        .sym_cnt   (sym_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        evt_valid = 1'b0;
        evt_props = '0;
        evt_aux   = '0;
        evt_last  = 1'b0;
        reset     = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_in_trace  = 1'b0;
        m_prev_last = 1'b0;
        m_wait      = 0;
        m_sym       = '0;
        m_tc        = '0;
        m_sc        = '0;
    endtask

    task automatic wait_run(input string name);
        for (int i = 0; i < 20 && run !== 1'b1; i++) @(negedge clk);
        chk(name, 32'(run), 1);
    endtask

    // pv/pl: percent of cycles offering a sample / percent of samples marked last.
    task automatic run_random(input int cycles, input int pv, input int pl);
        logic       acc;
        logic [8:0] pend;
        logic [8:0] head;
        logic       e_run;
        logic       e_mrst;
        for (int c = 0; c < cycles; c++) begin
            evt_valid = ($urandom_range(99) < pv);
            pend      = {($urandom_range(99) < pl), 8'($urandom)};
            {evt_last, evt_props, evt_aux} = pend;
            acc = evt_valid && (m_q.size() < DEPTH);
            if (!evt_ready) saw_full = 1'b1;
            @(negedge clk);
            e_run  = 1'b0;
            e_mrst = 1'b1;
            if (m_in_trace) begin
                e_mrst = 1'b0;
                if (m_prev_last) begin
                    m_in_trace = 1'b0;
                    e_mrst     = 1'b1;
                    m_wait     = 0;
                    m_tc++;
                end else if (m_q.size() > 0) begin
                    head        = m_q.pop_front();
                    e_run       = 1'b1;
                    m_sym       = head[7:0];
                    m_prev_last = head[8];
                    if (m_sc != 16'hFFFF) m_sc++;
                end
            end else if (m_wait == RST_CYCLES + 1) begin
                head        = m_q.pop_front();
                e_run       = 1'b1;
                e_mrst      = 1'b0;
                m_in_trace  = 1'b1;
                m_sym       = head[7:0];
                m_prev_last = head[8];
                m_sc        = 16'd1;
            end
            if (acc) m_q.push_back(pend);
            if (!m_in_trace && m_q.size() > 0) m_wait++;
            chk("rnd_run", 32'(run), 32'(e_run));
            chk("rnd_mon_reset", 32'(mon_reset), 32'(e_mrst));
            chk("rnd_symbols", 32'(symbols), 32'(m_sym));
            chk("rnd_evt_ready", 32'(evt_ready), 32'(m_q.size() < DEPTH));
            chk("rnd_busy", 32'(busy), 32'(m_in_trace || m_q.size() > 0));
            chk("rnd_trace_cnt", 32'(trace_cnt), 32'(m_tc));
            chk("rnd_sym_cnt", 32'(sym_cnt), 32'(m_sc));
        end
    endtask

    initial begin
        tbl[0] = '{1'b1, 4'h1, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 16'd0, 16'd0};
        tbl[1] = '{1'b1, 4'h2, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 16'd0, 16'd0};
        tbl[2] = '{1'b1, 4'h9, 4'h0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 16'd0, 16'd0};
        tbl[3] = '{1'b0, 4'h0, 4'h0, 1'b0, 8'h10, 1'b1, 1'b0, 1'b1, 16'd0, 16'd1};
        tbl[4] = '{1'b0, 4'h0, 4'h0, 1'b0, 8'h20, 1'b1, 1'b0, 1'b1, 16'd0, 16'd2};
        tbl[5] = '{1'b0, 4'h0, 4'h0, 1'b0, 8'h90, 1'b1, 1'b0, 1'b1, 16'd0, 16'd3};
        tbl[6] = '{1'b0, 4'h0, 4'h0, 1'b0, 8'h90, 1'b0, 1'b1, 1'b0, 16'd1, 16'd3};
        saw_full = 1'b0;

        evt_valid = 1'b0;
        evt_props = '0;
        evt_aux   = '0;
        evt_last  = 1'b0;
        reset     = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_symbols", 32'(symbols), 0);
        chk("rst_run", 32'(run), 0);
        chk("rst_mon_reset", 32'(mon_reset), 1);
        chk("rst_evt_ready", 32'(evt_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_trace_cnt", 32'(trace_cnt), 0);
        chk("rst_sym_cnt", 32'(sym_cnt), 0);
        reset = 1'b0;

        // Mid-trace asynchronous reset.
        for (int i = 0; i < 5; i++) begin
            evt_valid = 1'b1;
            evt_props = 4'(i + 1);
            evt_aux   = 4'h0;
            evt_last  = 1'b0;
            @(negedge clk);
        end
        evt_valid = 1'b0;
        wait_run("mtr_run_seen");
        #2 reset = 1'b1;
        #1;
        chk("mtr_run", 32'(run), 0);
        chk("mtr_mon_reset", 32'(mon_reset), 1);
        chk("mtr_evt_ready", 32'(evt_ready), 1);
        chk("mtr_busy", 32'(busy), 0);
        chk("mtr_trace_cnt", 32'(trace_cnt), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("mtr_after_run", 32'(run), 0);
        chk("mtr_after_busy", 32'(busy), 0);

        // Basic three-symbol trace, cycle by cycle.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            evt_valid = tbl[i].v;
            evt_props = tbl[i].p;
            evt_aux   = tbl[i].a;
            evt_last  = tbl[i].l;
            @(negedge clk);
            chk($sformatf("tbl%0d_symbols", i), 32'(symbols), 32'(tbl[i].sym));
            chk($sformatf("tbl%0d_run", i), 32'(run), 32'(tbl[i].run));
            chk($sformatf("tbl%0d_mon_reset", i), 32'(mon_reset), 32'(tbl[i].mrst));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_trace_cnt", i), 32'(trace_cnt), 32'(tbl[i].tc));
            chk($sformatf("tbl%0d_sym_cnt", i), 32'(sym_cnt), 32'(tbl[i].sc));
        end
        evt_valid = 1'b0;

        // Stall: one open symbol, a gap, then the closing symbol.
        do_reset();
        evt_valid = 1'b1;
        evt_props = 4'h1;
        evt_aux   = 4'h0;
        evt_last  = 1'b0;
        @(negedge clk);
        evt_valid = 1'b0;
        wait_run("stall_first_run");
        chk("stall_first_sym", 32'(symbols), 32'h10);
        repeat (5) begin
            @(negedge clk);
            chk("stall_gap_run", 32'(run), 0);
            chk("stall_gap_symbols", 32'(symbols), 32'h10);
            chk("stall_gap_mon_reset", 32'(mon_reset), 0);
        end
        evt_valid = 1'b1;
        evt_props = 4'h4;
        evt_last  = 1'b1;
        @(negedge clk);
        evt_valid = 1'b0;
        evt_last  = 1'b0;
        chk("stall_accept_run", 32'(run), 0);
        @(negedge clk);
        chk("stall_last_run", 32'(run), 1);
        chk("stall_last_sym", 32'(symbols), 32'h40);
        @(negedge clk);
        chk("stall_end_run", 32'(run), 0);
        chk("stall_end_mon_reset", 32'(mon_reset), 1);
        chk("stall_end_trace_cnt", 32'(trace_cnt), 1);
        chk("stall_end_sym_cnt", 32'(sym_cnt), 2);

        // Randomized phases against the reference model.
        do_reset();
        model_reset();
        run_random(1500, 50, 25);
        run_random(300, 100, 100);
        chk("full_seen", 32'(saw_full), 1);
        run_random(600, 100, 12);
        run_random(600, 10, 40);
        run_random(200, 0, 0);
        chk("drain_busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
